hex_count_source: RTL and testbench
===================================

HEX_COUNT_SOURCE -- requirements
Module: hex_count_source

Interface
REQ-001 Parameter PRESCALE, default 50000000: clk cycles per count step; legal range 2..2^26.
REQ-002 clk  input  1  rising-edge system clock; sole clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  high: prescaler runs; low: prescaler and count hold.
REQ-005 up  input  1  count direction: 1 = increment, 0 = decrement.
REQ-006 clr  input  1  synchronous clear of count and prescaler.
REQ-007 load  input  1  synchronous load of load_val into count.
REQ-008 load_val  input  16  value for load; four nibbles.
REQ-009 digit0..digit3  output  4 each  count nibbles [3:0]..[15:12]; each feeds one 7-segment hex decoder.
REQ-010 step  output  1  registered one-cycle pulse, high in the cycle after each count step.
REQ-011 wrap  output  1  registered one-cycle pulse, high in the cycle after a step crosses the range boundary.

Function
REQ-012 Prescaler pre: 26-bit register, counts 0..PRESCALE-1 while en=1 and wraps to 0; holds while en=0.
REQ-013 A step event occurs on the rising edge where en=1 and pre=PRESCALE-1.
REQ-014 On a step event, count (= {digit3,digit2,digit1,digit0}) becomes count+1 if up=1, count-1 if up=0.
REQ-015 Step latency: exactly PRESCALE enabled cycles between consecutive steps; the first step after reset/clr/load follows PRESCALE enabled cycles.
REQ-016 Hex mode range 0x0000..0xFFFF: up-step from 0xFFFF gives 0x0000 and sets wrap; down-step from 0x0000 gives 0xFFFF and sets wrap.
REQ-017 step and wrap are high for exactly one cycle, in the cycle after the step edge; wrap is never high without step.
REQ-018 Priority per edge: clr > load > step event.
REQ-019 clr=1: count <= 0, pre <= 0, no step/wrap pulse that cycle, regardless of en.
REQ-020 load=1 (clr=0): count <= load_val (after REQ-026 legalisation), pre <= 0, no step/wrap pulse, regardless of en.
REQ-021 A step event coinciding with clr or load is discarded, not deferred.
REQ-022 Changing up takes effect at the next step event; pre is unaffected.
REQ-023 Deasserting en mid-period freezes pre; reasserting resumes from the frozen value.
REQ-024 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-025 rst_n=0 immediately forces count=0x0000 (all digits 0), pre=0, step=0, wrap=0; release is synchronous to clk in the design using the block; first step follows PRESCALE enabled cycles after release.

Configuration
REQ-026 Macro HEX_COUNT_BCD_EN defined: each digit counts 0..9 decimal with nibble carry/borrow; range 0000..9999; up from 9999 gives 0000 with wrap; down from 0000 gives 9999 with wrap; load_val nibbles above 9 load as 9.
REQ-027 HEX_COUNT_BCD_EN undefined: pure binary 16-bit hex counting per REQ-016; load_val loads unmodified.

Verification (PRESCALE=4 unless noted)
REQ-028 Reset, en=1, up=1, 12 cycles -> count 0x0003; step high in cycles 5, 9, 13 after release; wrap never high.
REQ-029 load 0xFFFE, up=1, en=1, 8 cycles -> 0xFFFF then 0x0000; wrap pulses once, coincident with the step reporting 0x0000.
REQ-030 load 0x0001, up=0, 8 cycles -> 0x0000 then 0xFFFF with one wrap pulse; BCD build: 0x0000 down -> 0x9999 with wrap.
REQ-031 Assert clr exactly on a step-event edge with count 0x1234 -> count 0x0000, no step pulse; next step 4 enabled cycles later gives 0x0001.
REQ-032 en low for 10 cycles at pre=2 -> count and pre frozen; step occurs 2 cycles after en returns high.
REQ-033 Drop rst_n mid-period with count 0x00A5 -> digits 0 immediately, without a clk edge; BCD build: load 0x0A5F -> count 0x0959, +1 step -> 0x0960.

Source files
------------

// File: rtl/hex_count_source_if.sv
// Control inputs and display/pulse outputs of hex_count_source, grouped as one bundle.
// master = whoever drives the controls (bench or parent); slave = the counter itself.
interface hex_count_if;
  logic        en;
  logic        up;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic [3:0]  digit0;
  logic [3:0]  digit1;
  logic [3:0]  digit2;
  logic [3:0]  digit3;
  logic        step;
  logic        wrap;

  modport master (
    output en, up, clr, load, load_val,
    input  digit0, digit1, digit2, digit3, step, wrap
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output digit0, digit1, digit2, digit3, step, wrap
  );
endinterface

// File: rtl/hex_count_source.sv
// Prescaled four-digit up/down counter driving 7-segment digit nibbles, with step/wrap pulses.
// Define HEX_COUNT_BCD_EN for decimal digits (0000..9999); default build counts binary 0000..FFFF.
module hex_count_source #(
    parameter int PRESCALE = 50000000
) (
    input logic        clk,
    input logic        rst_n,
    hex_count_if.slave bus
);

    localparam logic [25:0] PRE_LAST = 26'(PRESCALE - 1);

`ifdef HEX_COUNT_BCD_EN
    localparam logic [15:0] CNT_MAX = 16'h9999;

    // Ripple a +1/-1 through decimal nibbles; each nibble wraps 9<->0 and passes a carry/borrow.
    function automatic logic [15:0] count_next(input logic [15:0] c, input logic dir_up);
        logic [15:0] r;
        logic        carry;
        logic [3:0]  nib;
        r     = c;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nib = c[4*i +: 4];
            if (carry) begin
                if (dir_up) begin
                    if (nib >= 4'd9) nib = 4'd0;
                    else begin
                        nib   = nib + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0) nib = 4'd9;
                    else begin
                        nib   = nib - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            r[4*i +: 4] = nib;
        end
        return r;
    endfunction

    function automatic logic [15:0] legalise(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction
`else
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] count_next(input logic [15:0] c, input logic dir_up);
        return dir_up ? c + 16'd1 : c - 16'd1;
    endfunction

    function automatic logic [15:0] legalise(input logic [15:0] v);
        return v;
    endfunction
`endif

    logic [25:0] pre_q,   pre_d;
    logic [15:0] count_q, count_d;
    logic        step_q,  step_d;
    logic        wrap_q,  wrap_d;
    logic        step_evt;

    assign step_evt = bus.en && (pre_q == PRE_LAST);

    // clr beats load beats step; a step landing on a clr/load edge is dropped.
    always_comb begin
        pre_d   = pre_q;
        count_d = count_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        if (bus.clr) begin
            pre_d   = '0;
            count_d = '0;
        end else if (bus.load) begin
            pre_d   = '0;
            count_d = legalise(bus.load_val);
        end else if (step_evt) begin
            pre_d   = '0;
            count_d = count_next(count_q, bus.up);
            step_d  = 1'b1;
            wrap_d  = bus.up ? (count_q == CNT_MAX) : (count_q == 16'h0000);
        end else if (bus.en) begin
            pre_d = pre_q + 26'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            count_q <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.digit0 = count_q[3:0];
    assign bus.digit1 = count_q[7:4];
    assign bus.digit2 = count_q[11:8];
    assign bus.digit3 = count_q[15:12];
    assign bus.step   = step_q;
    assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_hex_count_source.sv
// Bench for hex_count_source with PRESCALE=4: a table of operations with expected count and
// pulse tallies, a short reset-mid-period sequence, and a randomised load/run section.
module tb_hex_count_source;

    localparam int PRESCALE = 4;

`ifdef HEX_COUNT_BCD_EN
    localparam logic [15:0] TOP     = 16'h9999;
    localparam int          TOP_INT = 9999;
`else
    localparam logic [15:0] TOP     = 16'hFFFF;
    localparam int          TOP_INT = 65535;
`endif
    localparam logic [15:0] TOP_M1 = TOP - 16'd1;

    typedef struct {
        logic        clr;
        logic        load;
        logic [15:0] load_val;
        logic        en;
        logic        up;
        int          cycles;
        logic [15:0] exp_count;
        int          exp_steps;
        int          exp_wraps;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hex_count_if bus ();

    hex_count_source #(.PRESCALE(PRESCALE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vec_t        vecs[$];
    logic [15:0] exp_q[$];
    int          total = 0;
    int          bad = 0;

    function automatic logic [15:0] cur_count();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s idx=%0d got=%0h expected=%0h", name, idx, got, exp);
        end
    endtask

    task automatic add_vec(input logic clr, input logic load, input logic [15:0] lv, input logic en,
                           input logic up, input int cycles, input logic [15:0] ec, input int es,
                           input int ew);
        vec_t v;
        v.clr = clr; v.load = load; v.load_val = lv; v.en = en; v.up = up;
        v.cycles = cycles; v.exp_count = ec; v.exp_steps = es; v.exp_wraps = ew;
        vecs.push_back(v);
    endtask

    // Controls are applied for the first edge only for clr/load; en/up hold for the whole op.
    task automatic apply_op(input vec_t v, input int idx);
        int          steps, wraps, orphans;
        logic [15:0] exp;
        steps = 0; wraps = 0; orphans = 0;
        bus.clr = v.clr; bus.load = v.load; bus.load_val = v.load_val;
        bus.en = v.en; bus.up = v.up;
        exp_q.push_back(v.exp_count);
        for (int c = 0; c < v.cycles; c++) begin
            @(posedge clk);
            #1;
            bus.clr = 1'b0;
            bus.load = 1'b0;
            if (bus.step) steps++;
            if (bus.wrap) wraps++;
            if (bus.wrap && !bus.step) orphans++;
        end
        exp = exp_q.pop_front();
        check("count", idx, 32'(cur_count()), 32'(exp));
        check("steps", idx, steps, v.exp_steps);
        check("wraps", idx, wraps, v.exp_wraps);
        check("wrap_without_step", idx, orphans, 0);
    endtask

    function automatic int to_int(input logic [15:0] v);
`ifdef HEX_COUNT_BCD_EN
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
`else
        return int'(v);
`endif
    endfunction

    function automatic logic [15:0] from_int(input int n);
`ifdef HEX_COUNT_BCD_EN
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
`else
        return 16'(n);
`endif
    endfunction

    initial begin
        vec_t        v;
        logic [15:0] lv;
        int          k, d, nd;
        logic        dir;

        bus.en = 1'b0; bus.up = 1'b1; bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 0, 32'(cur_count()), 32'h0);
        check("reset_step", 0, 32'(bus.step), 32'h0);
        check("reset_wrap", 0, 32'(bus.wrap), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        add_vec(0, 0, 16'h0000, 1, 1, 12, 16'h0003, 3, 0);
        add_vec(0, 1, TOP_M1,   1, 1, 9,  16'h0000, 2, 1);
        add_vec(0, 1, 16'h0001, 1, 0, 9,  TOP,      2, 1);
        add_vec(1, 0, 16'h0000, 0, 1, 1,  16'h0000, 0, 0);
        add_vec(0, 1, 16'h1234, 1, 1, 4,  16'h1234, 0, 0);
        add_vec(1, 0, 16'h0000, 1, 1, 1,  16'h0000, 0, 0);
        add_vec(0, 0, 16'h0000, 1, 1, 4,  16'h0001, 1, 0);
        add_vec(1, 0, 16'h0000, 1, 1, 1,  16'h0000, 0, 0);
        add_vec(0, 0, 16'h0000, 1, 1, 2,  16'h0000, 0, 0);
        add_vec(0, 0, 16'h0000, 0, 1, 10, 16'h0000, 0, 0);
        add_vec(0, 0, 16'h0000, 1, 1, 1,  16'h0000, 0, 0);
        add_vec(0, 0, 16'h0000, 1, 1, 1,  16'h0001, 1, 0);
        add_vec(0, 1, 16'h0090, 1, 1, 4,  16'h0090, 0, 0);
        add_vec(1, 1, 16'h1111, 1, 1, 1,  16'h0000, 0, 0);
        add_vec(0, 1, 16'h0010, 1, 1, 4,  16'h0010, 0, 0);
        add_vec(0, 1, 16'h0020, 1, 1, 1,  16'h0020, 0, 0);
        add_vec(0, 0, 16'h0000, 1, 1, 4,  16'h0021, 1, 0);
        add_vec(0, 1, 16'h0025, 1, 0, 9,  16'h0023, 2, 0);
        add_vec(0, 0, 16'h0000, 1, 1, 2,  16'h0023, 0, 0);
        add_vec(0, 0, 16'h0000, 1, 0, 2,  16'h0022, 1, 0);

        for (int i = 0; i < vecs.size(); i++) apply_op(vecs[i], i + 1);

        // Reset dropped mid-period must clear the digits without waiting for a clock edge.
`ifdef HEX_COUNT_BCD_EN
        add_vec(0, 1, 16'h0A5F, 1, 1, 3, 16'h0959, 0, 0);
`else
        add_vec(0, 1, 16'h00A5, 1, 1, 3, 16'h00A5, 0, 0);
`endif
        apply_op(vecs[vecs.size() - 1], 100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_count", 101, 32'(cur_count()), 32'h0);
        check("async_reset_step", 101, 32'(bus.step), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        add_vec(0, 0, 16'h0000, 1, 1, 4, 16'h0001, 1, 0);
        apply_op(vecs[vecs.size() - 1], 102);
`ifdef HEX_COUNT_BCD_EN
        add_vec(0, 1, 16'h0A5F, 1, 1, 5, 16'h0960, 1, 0);
        apply_op(vecs[vecs.size() - 1], 103);
`endif

        // Random loads near and away from the range ends, then k steps in a random direction.
        for (int r = 0; r < 16; r++) begin
            k   = int'($urandom_range(1, 5));
            dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) d = dir ? TOP_INT - int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
            else d = int'($urandom_range(0, TOP_INT));
            lv = from_int(d);
            nd = dir ? (d + k) % (TOP_INT + 1) : (d - k + TOP_INT + 1) % (TOP_INT + 1);
            v.clr = 1'b0; v.load = 1'b1; v.load_val = lv; v.en = 1'b1; v.up = dir;
            v.cycles = 1 + PRESCALE * k;
            v.exp_count = from_int(nd);
            v.exp_steps = k;
            v.exp_wraps = dir ? int'(d + k > TOP_INT) : int'(d < k);
            apply_op(v, 200 + r);
            check("model_roundtrip", 200 + r, 32'(to_int(lv)), 32'(d));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
